// File: rtl/dbus_bridge.sv
// dbus_bridge: turns one core memory-stage access into one aligned word
// transaction on the request/acknowledge bus, stalling the core via HLT.
// Misaligned / malformed accesses are trapped without touching the bus.
// Optional build macro: DBUS_TIMEOUT_EN adds a REQ watchdog of TIMEOUT cycles.
module dbus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  input  logic [2:0]  DLEN,
  input  logic        DRD,
  input  logic        DWR,
  input  logic        DAS,
  output logic [31:0] DATAI,
  output logic        HLT,
  output logic        BERR,
  output logic [31:0] BUS_ADDR,
  output logic [31:0] BUS_WDATA,
  output logic [3:0]  BUS_BE,
  output logic        BUS_WE,
  output logic        BUS_REQ,
  input  logic        BUS_ACK,
  input  logic [31:0] BUS_RDATA,
  input  logic        BUS_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        req_q;
  logic [31:0] datai_q;
  logic        berr_q;

  logic        start;
  logic        len_ok;
  logic        align_ok;
  logic        legal;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

`ifdef DBUS_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q;
`else
  // Watchdog absent: the parameter is accepted but has no effect.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  // Decode the presented access: start, legality and lane placement.
  always_comb begin
    start    = DAS & (DRD | DWR);
    len_ok   = 1'b0;
    align_ok = 1'b0;
    be_d     = 4'b0000;
    case (DLEN)
      3'd1: begin
        len_ok   = 1'b1;
        align_ok = 1'b1;
        be_d     = 4'b0001 << DADDR[1:0];
      end
      3'd2: begin
        len_ok   = 1'b1;
        align_ok = ~DADDR[0];
        be_d     = 4'b0011 << {DADDR[1], 1'b0};
      end
      3'd4: begin
        len_ok   = 1'b1;
        align_ok = (DADDR[1:0] == 2'b00);
        be_d     = 4'b1111;
      end
      default: begin
        len_ok   = 1'b0;
        align_ok = 1'b0;
        be_d     = 4'b0000;
      end
    endcase
    // Reads always fetch the whole word; the core extracts its lanes.
    if (!DWR) begin
      be_d = 4'b1111;
    end
    legal   = (DRD ^ DWR) & len_ok & align_ok;
    wdata_d = DWR ? (DATAO << {DADDR[1:0], 3'b000}) : 32'd0;
  end

  // Stall is combinational so the core freezes in the very cycle it asks.
  assign HLT = RES & (((state_q == ST_IDLE) & start) | (state_q == ST_REQ));

  assign DATAI     = datai_q;
  assign BERR      = berr_q;
  assign BUS_ADDR  = addr_q;
  assign BUS_WDATA = wdata_q;
  assign BUS_BE    = be_q;
  assign BUS_WE    = we_q;
  assign BUS_REQ   = req_q;

  // Access sequencer with all bus and core-facing outputs registered.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      datai_q <= 32'd0;
      berr_q  <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      cnt_q   <= 16'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          berr_q <= 1'b0;
          if (start) begin
            if (legal) begin
              addr_q  <= {DADDR[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              we_q    <= DWR;
              req_q   <= 1'b1;
              state_q <= ST_REQ;
`ifdef DBUS_TIMEOUT_EN
              cnt_q   <= 16'd0;
`endif
            end else begin
              // Trapped locally: report the error without a bus cycle.
              datai_q <= 32'd0;
              berr_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_REQ: begin
          if (BUS_ACK) begin
            req_q   <= 1'b0;
            datai_q <= we_q ? 32'd0 : BUS_RDATA;
            berr_q  <= BUS_ERR;
            state_q <= ST_DONE;
          end
`ifdef DBUS_TIMEOUT_EN
          // An ACK on the terminal-count cycle takes priority above.
          else if (cnt_q == TIMEOUT_LAST) begin
            req_q   <= 1'b0;
            datai_q <= 32'd0;
            berr_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        ST_DONE: begin
          // The core still shows the finished access here; never restart it.
          berr_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
